// File: rtl/aq_idu_free_idx_alloc.sv
// 32-entry free-index allocator: registered free bitmap, lowest-free-entry
// priority encode for allocation, 5-bit release expanded back into the bitmap.
module aq_idu_free_idx_alloc #(
  parameter bit RSV_ZERO = 1'b1
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        alloc_req,
  output logic        alloc_vld,
  output logic [4:0]  alloc_idx,
  output logic [31:0] alloc_onehot,
  input  logic        rel_vld,
  input  logic [4:0]  rel_idx,
  input  logic        flush,
  input  logic        err_clr,
  output logic [5:0]  free_cnt,
  output logic        rel_err
);

  // Handshake: alloc_vld acts as ready for alloc_req; a grant happens only in a
  // cycle where both are high, and the granted index is the alloc_idx shown in
  // that same cycle. rel_vld has no back-pressure: every release is consumed,
  // illegal ones only raise the sticky rel_err.

  localparam logic [31:0] RST_VEC = RSV_ZERO ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
  localparam logic [5:0]  RST_CNT = RSV_ZERO ? 6'd31 : 6'd32;

  logic [31:0] r_free_vec;
  logic [5:0]  r_free_cnt;
  logic        r_rel_err;

  logic [4:0]  w_low_idx;
  logic        w_grant;
  logic        w_rel_legal;
  logic        w_rel_illegal;
  logic [31:0] w_free_vec_nxt;
  logic [5:0]  w_free_cnt_nxt;
  logic        w_rel_err_nxt;

  // Scanning downward leaves the lowest set bit as the final assignment.
  always_comb begin
    w_low_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (r_free_vec[i]) w_low_idx = 5'(i);
    end
  end

  assign alloc_vld    = |r_free_vec;
  assign alloc_idx    = w_low_idx;
  assign alloc_onehot = r_free_vec & (~r_free_vec + 32'd1);
  assign free_cnt     = r_free_cnt;
  assign rel_err      = r_rel_err;

  assign w_grant       = alloc_req & alloc_vld;
  assign w_rel_legal   = rel_vld & ~r_free_vec[rel_idx] &
                         ~(RSV_ZERO && (rel_idx == 5'd0));
  assign w_rel_illegal = rel_vld & ~w_rel_legal;

  always_comb begin
    w_free_vec_nxt = r_free_vec;
    w_free_cnt_nxt = r_free_cnt;
    w_rel_err_nxt  = r_rel_err;
    if (flush) begin
      w_free_vec_nxt = RST_VEC;
      w_free_cnt_nxt = RST_CNT;
    end else begin
      // Grant and legal release always touch different bits, so both can apply.
      if (w_grant)     w_free_vec_nxt = w_free_vec_nxt & ~alloc_onehot;
      if (w_rel_legal) w_free_vec_nxt = w_free_vec_nxt | (32'd1 << rel_idx);
      if (w_grant && !w_rel_legal)      w_free_cnt_nxt = r_free_cnt - 6'd1;
      else if (!w_grant && w_rel_legal) w_free_cnt_nxt = r_free_cnt + 6'd1;
    end
    if (w_rel_illegal && !flush) w_rel_err_nxt = 1'b1;
    else if (err_clr)            w_rel_err_nxt = 1'b0;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_free_vec <= RST_VEC;
      r_free_cnt <= RST_CNT;
      r_rel_err  <= 1'b0;
    end else begin
      r_free_vec <= w_free_vec_nxt;
      r_free_cnt <= w_free_cnt_nxt;
      r_rel_err  <= w_rel_err_nxt;
    end
  end

endmodule

// File: doc/aq_idu_free_idx_alloc.md
Name: aq_idu_free_idx_alloc

Overview:
- 32-entry free-index allocator for the IDU. It is the encode direction of the 5-bit-to-one-hot expand path.
- Holds a registered 32-bit free bitmap and priority-encodes the lowest free entry into a 5-bit index for allocation.
- Released 5-bit indices are expanded back into the bitmap.
- Used for rename/dependency tag allocation; the consumer issues alloc/release handshakes each cycle.

Parameters:
- RSV_ZERO, 1, when 1 entry 0 is permanently reserved: never allocated, never freed.

Ports:
- forever_cpuclk  input  1  clock, all state on rising edge.
- cpurst_b  input  1  asynchronous active-low reset.
- alloc_req  input  1  consumer requests one index this cycle.
- alloc_vld  output  1  a free index is available (bitmap non-empty).
- alloc_idx  output  5  lowest-numbered free index; valid when alloc_vld.
- alloc_onehot  output  32  one-hot of alloc_idx; all-zero when !alloc_vld.
- rel_vld  input  1  release request.
- rel_idx  input  5  index being released.
- flush  input  1  restore all entries to free.
- err_clr  input  1  clear sticky error.
- free_cnt  output  6  number of free entries.
- rel_err  output  1  sticky: an illegal release was observed.

Behaviour:
- State is free_vec[31:0], free_cnt[5:0] and rel_err, all registered. A bit value of 1 means the entry is free.
- Reset values:
  - free_vec = 32'hFFFF_FFFE and free_cnt = 31 if RSV_ZERO; otherwise 32'hFFFF_FFFF and 32.
  - rel_err = 0.
- Derived outputs, combinational from registered state only (no input-to-output paths):
  - alloc_vld = |free_vec.
  - alloc_idx = index of the lowest set bit of free_vec; 0 when the bitmap is empty.
  - After reset: alloc_vld=1; alloc_idx=1 (RSV_ZERO=1) or 0 (RSV_ZERO=0).
- Allocation:
  - Grant = alloc_req & alloc_vld.
  - On grant, bit alloc_idx clears at the next edge and free_cnt decrements.
  - alloc_req with !alloc_vld has no effect and no error.
  - One allocation per cycle at most.
- Release:
  - Legal release = rel_vld & free_vec[rel_idx]==0 & !(RSV_ZERO & rel_idx==0).
  - A legal release sets the bit at the next edge and increments free_cnt.
  - An illegal release (already free, or reserved entry 0) leaves free_vec unchanged and sets rel_err at the next edge.
- Simultaneous grant and legal release (distinct bits by construction):
  - Both apply in the same edge; free_cnt is unchanged.
  - No bypass: the released index is not visible on alloc_idx until the next cycle, even if the bitmap was empty.
- Simultaneous grant and release of the same index: the bit is currently free, so the release is illegal. The grant takes effect and rel_err sets.
- flush:
  - Highest priority. free_vec and free_cnt return to their reset values at the next edge.
  - Concurrent alloc and release are ignored and produce no error.
  - rel_err is unchanged by flush.
- rel_err:
  - Cleared by err_clr at the next edge.
  - If err_clr and a new illegal release occur in the same cycle, set wins (rel_err=1).
- Invariant: free_cnt always equals popcount(free_vec). Range is 0..31 (RSV_ZERO=1) or 0..32.
- Asynchronous reset mid-operation immediately forces all reset values, regardless of pending requests.

Test Plan:
- Reset (RSV_ZERO=1), check outputs -> alloc_vld=1, alloc_idx=1, alloc_onehot=32'h2, free_cnt=31, rel_err=0.
- Hold alloc_req for 31 cycles -> granted indices are 1,2,...,31 in order, with free_cnt stepping 30..0. Then alloc_vld=0, alloc_idx=0, alloc_onehot=0, and a 32nd alloc_req changes nothing.
- From the empty bitmap, rel_vld with rel_idx=17 -> next cycle alloc_vld=1, alloc_idx=17, free_cnt=1. The same-cycle alloc_req is not granted (no bypass).
- With entries 1..5 allocated, drive alloc_req together with rel_vld/rel_idx=3 -> next cycle bit 6 is cleared, bit 3 is set, free_cnt unchanged at 26, and the following alloc_idx=3.
- Release idx 9 while it is free, and separately release idx 0 -> rel_err=1 and free_vec unchanged. Assert err_clr alone -> rel_err=0. Assert err_clr with another illegal release -> rel_err stays 1.
- With 10 entries allocated, assert flush together with alloc_req and rel_vld -> next cycle free_vec=32'hFFFF_FFFE, free_cnt=31, rel_err unchanged. Also pulse cpurst_b low mid-allocation -> outputs return to reset values immediately.
